// File: rtl/logic_unit_arbiter.sv
// Two-port arbiter in front of a shared 32-bit XOR/OR/AND unit.
// One transaction in flight; the result is held on a per-port valid/ready response channel.
module logic_unit_arbiter #(
    parameter int unsigned BITS       = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [BITS-1:0] a0,
    input  logic [BITS-1:0] b0,
    input  logic [1:0]      sel0,
    input  logic [BITS-1:0] a1,
    input  logic [BITS-1:0] b1,
    input  logic [1:0]      sel1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            owner_r;
    logic            last_grant_r;
    logic [BITS-1:0] a_r;
    logic [BITS-1:0] b_r;
    logic [1:0]      sel_r;
    logic [BITS-1:0] result_r;
    logic [1:0]      rsp_valid_r;
    logic            busy_r;

    logic            hs_s;
    logic            window_s;
    logic            winner_s;
    logic            accept_s;
    logic [1:0]      req_ready_s;

    // sel = 11 deliberately aliases AND
    function automatic logic [BITS-1:0] lu_op(
        input logic [BITS-1:0] op_a,
        input logic [BITS-1:0] op_b,
        input logic [1:0]      op_sel
    );
        logic [BITS-1:0] res;
        case (op_sel)
            2'b00:   res = op_a ^ op_b;
            2'b01:   res = op_a | op_b;
            default: res = op_a & op_b;
        endcase
        return res;
    endfunction

    // Winner selection: single requester wins, ties go by priority mode
    always_comb begin
        winner_s = 1'b0;
        case (req_valid)
            2'b01:   winner_s = 1'b0;
            2'b10:   winner_s = 1'b1;
            2'b11:   winner_s = (FIXED_PRIO == 1'b1) ? 1'b0 : ~last_grant_r;
            default: winner_s = 1'b0;
        endcase
    end

    // Grant window is IDLE, or RESP in the cycle the owner takes its result
    always_comb begin
        hs_s        = 1'b0;
        window_s    = 1'b0;
        accept_s    = 1'b0;
        req_ready_s = 2'b00;
        if (state_r == ST_RESP) begin
            hs_s = rsp_ready[owner_r];
        end else begin
            hs_s = 1'b0;
        end
        window_s = (state_r == ST_IDLE) || hs_s;
        accept_s = window_s && (req_valid != 2'b00);
        if (accept_s) begin
            req_ready_s = winner_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (hs_s && accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else if (hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, operand capture, result and registered response flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            a_r          <= '0;
            b_r          <= '0;
            sel_r        <= 2'b00;
            result_r     <= '0;
            rsp_valid_r  <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                owner_r      <= winner_s;
                last_grant_r <= winner_s;
                a_r          <= winner_s ? a1 : a0;
                b_r          <= winner_s ? b1 : b0;
                sel_r        <= winner_s ? sel1 : sel0;
            end
            if (state_r == ST_EXEC) begin
                result_r <= lu_op(a_r, b_r, sel_r);
            end
            // Owner cannot change on the EXEC->RESP edge, so owner_r is already correct
            if (state_nxt_s == ST_RESP) begin
                rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
            end else begin
                rsp_valid_r <= 2'b00;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = result_r;
    assign busy      = busy_r;

endmodule
